// File: rtl/rx_word_gather.sv
// Gathers WORDS narrow receive words into one wide block with start-of-block
// framing, emitting a single-cycle dout_valid pulse per completed block.
module rx_word_gather #(
  parameter int WORD_W = 20,
  parameter int WORDS  = 20,
  parameter int CNT_W  = $clog2(WORDS)
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [WORD_W-1:0]         din,
  input  logic                      din_valid,
  input  logic                      din_sof,
  output logic [WORDS*WORD_W-1:0]   dout,
  output logic                      dout_valid,
  output logic                      locked,
  output logic                      frame_err
);

  typedef enum logic {HUNT, GATHER} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WORDS*WORD_W-1:0]   asm_q, asm_d;
  logic [WORDS*WORD_W-1:0]   dout_q, dout_d;
  logic                      dout_valid_q, dout_valid_d;
  logic                      frame_err_q, frame_err_d;

  logic [WORDS*WORD_W-1:0]   asm_slot;
  logic [WORDS*WORD_W-1:0]   asm_first;
  logic                      last_word;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      asm_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Constant-index slot write keeps the part-select free of a runtime index.
  always_comb begin
    asm_slot = asm_q;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (cnt_q == CNT_W'(k)) asm_slot[k*WORD_W +: WORD_W] = din;
    end
    asm_first = asm_q;
    asm_first[0 +: WORD_W] = din;
    last_word = (cnt_q == CNT_W'(WORDS - 1));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (din_sof) begin
            asm_d   = asm_first;
            cnt_d   = CNT_W'(1);
            state_d = GATHER;
          end
        end
        GATHER: begin
          if (cnt_q != '0) begin
            if (!din_sof) begin
              asm_d = asm_slot;
              if (last_word) begin
                // Final word goes straight into dout on the same edge.
                dout_d       = asm_slot;
                dout_valid_d = 1'b1;
                cnt_d        = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end else begin
              frame_err_d = 1'b1;
              asm_d       = asm_first;
              cnt_d       = CNT_W'(1);
            end
          end else begin
            if (din_sof) begin
              asm_d = asm_first;
              cnt_d = CNT_W'(1);
            end else begin
              frame_err_d = 1'b1;
              state_d     = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = (state_q == GATHER);
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_rx_word_gather.sv
// Directed table-driven bench for rx_word_gather with WORDS=4, WORD_W=8.
module tb_rx_word_gather;

  localparam int WORD_W = 8;
  localparam int WORDS  = 4;

  logic                    clk = 1'b0;
  logic                    arst;
  logic [WORD_W-1:0]       din;
  logic                    din_valid;
  logic                    din_sof;
  logic [WORDS*WORD_W-1:0] dout;
  logic                    dout_valid;
  logic                    locked;
  logic                    frame_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  rx_word_gather #(.WORD_W(WORD_W), .WORDS(WORDS)) dut (
    .clk        (clk),
    .arst       (arst),
    .din        (din),
    .din_valid  (din_valid),
    .din_sof    (din_sof),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic        e_dv;
    logic [31:0] e_dout;
    logic        e_lk;
    logic        e_fe;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic s, input logic [7:0] d,
                     input logic e_dv, input logic [31:0] e_dout,
                     input logic e_lk, input logic e_fe);
    vec_t r;
    r.v = v; r.s = s; r.d = d;
    r.e_dv = e_dv; r.e_dout = e_dout; r.e_lk = e_lk; r.e_fe = e_fe;
    tbl.push_back(r);
  endtask

  // Apply one cycle of input; return #1 after the consuming edge.
  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    din_valid = v;
    din_sof   = s;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_dv, input logic [31:0] e_dout,
                         input logic e_lk, input logic e_fe);
    chk({tag, " dout_valid"}, {31'd0, dout_valid}, {31'd0, e_dv});
    chk({tag, " dout"},       dout,                e_dout);
    chk({tag, " locked"},     {31'd0, locked},     {31'd0, e_lk});
    chk({tag, " frame_err"},  {31'd0, frame_err},  {31'd0, e_fe});
  endtask

  initial begin
    // Basic block
    add(1, 1, 8'h11, 0, 32'h0000_0000, 1, 0);
    add(1, 0, 8'h22, 0, 32'h0000_0000, 1, 0);
    add(1, 0, 8'h33, 0, 32'h0000_0000, 1, 0);
    add(1, 0, 8'h44, 1, 32'h4433_2211, 1, 0);
    add(0, 0, 8'h00, 0, 32'h4433_2211, 1, 0);
    // Missing marker drops back to HUNT
    add(1, 0, 8'h99, 0, 32'h4433_2211, 0, 1);
    add(1, 0, 8'hAA, 0, 32'h4433_2211, 0, 0);
    add(1, 0, 8'hBB, 0, 32'h4433_2211, 0, 0);
    add(0, 1, 8'hCC, 0, 32'h4433_2211, 0, 0);
    // Gapped block from HUNT
    add(1, 1, 8'h01, 0, 32'h4433_2211, 1, 0);
    add(0, 0, 8'h00, 0, 32'h4433_2211, 1, 0);
    add(1, 0, 8'h02, 0, 32'h4433_2211, 1, 0);
    add(0, 0, 8'h00, 0, 32'h4433_2211, 1, 0);
    add(1, 0, 8'h03, 0, 32'h4433_2211, 1, 0);
    add(0, 0, 8'h00, 0, 32'h4433_2211, 1, 0);
    add(1, 0, 8'h04, 1, 32'h0403_0201, 1, 0);
    add(0, 0, 8'h00, 0, 32'h0403_0201, 1, 0);
    add(0, 0, 8'h00, 0, 32'h0403_0201, 1, 0);
    // Premature marker
    add(1, 1, 8'h11, 0, 32'h0403_0201, 1, 0);
    add(1, 0, 8'h22, 0, 32'h0403_0201, 1, 0);
    add(1, 1, 8'h55, 0, 32'h0403_0201, 1, 1);
    add(1, 0, 8'h66, 0, 32'h0403_0201, 1, 0);
    add(1, 0, 8'h77, 0, 32'h0403_0201, 1, 0);
    add(1, 0, 8'h88, 1, 32'h8877_6655, 1, 0);
    // Back-to-back blocks
    add(1, 1, 8'h11, 0, 32'h8877_6655, 1, 0);
    add(1, 0, 8'h22, 0, 32'h8877_6655, 1, 0);
    add(1, 0, 8'h33, 0, 32'h8877_6655, 1, 0);
    add(1, 0, 8'h44, 1, 32'h4433_2211, 1, 0);
    add(1, 1, 8'h55, 0, 32'h4433_2211, 1, 0);
    add(1, 0, 8'h66, 0, 32'h4433_2211, 1, 0);
    add(1, 0, 8'h77, 0, 32'h4433_2211, 1, 0);
    add(1, 0, 8'h88, 1, 32'h8877_6655, 1, 0);
    add(0, 0, 8'h00, 0, 32'h8877_6655, 1, 0);

    arst = 1'b1; din = '0; din_valid = 1'b0; din_sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 32'h0, 0, 0);
    arst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d);
      chk_all($sformatf("v%0d", i), tbl[i].e_dv, tbl[i].e_dout, tbl[i].e_lk, tbl[i].e_fe);
    end

    // Asynchronous reset mid-block clears everything without a clock edge
    drive(1, 1, 8'h11);
    drive(1, 0, 8'h22);
    chk_all("pre_arst", 0, 32'h8877_6655, 1, 0);
    din_valid = 1'b0;
    #2 arst = 1'b1;
    #1;
    chk_all("mid_arst", 0, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    drive(1, 0, 8'h33);
    chk_all("post_drop1", 0, 32'h0, 0, 0);
    drive(1, 0, 8'h44);
    chk_all("post_drop2", 0, 32'h0, 0, 0);
    drive(1, 1, 8'hA1);
    chk_all("post_w0", 0, 32'h0, 1, 0);
    drive(1, 0, 8'hA2);
    drive(1, 0, 8'hA3);
    chk_all("post_w2", 0, 32'h0, 1, 0);
    drive(1, 0, 8'hA4);
    chk_all("post_done", 1, 32'hA4A3_A2A1, 1, 0);
    drive(0, 0, 8'h00);
    chk_all("post_idle", 0, 32'hA4A3_A2A1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
